// File: rtl/batch_normalization_pipelined.sv
// Two-stage pipelined, multi-channel batch-norm: u_out = sat(u + addend[ch] + factor[ch]*z),
// with per-channel parameters loaded through a config port and a saturating clip-event counter.
module batch_normalization_pipelined #(
  parameter int WIDTH        = 6,
  parameter int ADDEND_WIDTH = WIDTH - 2,
  parameter int CHANNELS     = 4,
  parameter int CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [CH_BITS-1:0]             cfg_ch,
  input  logic [3:0]                     cfg_factor,
  input  logic signed [ADDEND_WIDTH-1:0] cfg_addend,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CH_BITS-1:0]             in_ch,
  input  logic signed [WIDTH-1:0]        u,
  input  logic signed [WIDTH-1:0]        z,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CH_BITS-1:0]             out_ch,
  output logic signed [WIDTH-1:0]        u_out,
  output logic                           out_sat,
  output logic [CNT_WIDTH-1:0]           sat_count,
  input  logic                           sat_clr
);

  // Wide enough that u + addend + 4z + 8z can never wrap.
  localparam int SW = WIDTH + 5;
  localparam logic signed [SW-1:0] MAX_V = SW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_V = SW'(-(1 << (WIDTH - 1)));

  logic [3:0]                     factor_q [CHANNELS];
  logic signed [ADDEND_WIDTH-1:0] addend_q [CHANNELS];

  logic                    s1_valid_q, s2_valid_q;
  logic [CH_BITS-1:0]      s1_ch_q, s2_ch_q;
  logic signed [SW-1:0]    s1_sum_q;
  logic signed [WIDTH-1:0] s2_val_q;
  logic                    s2_sat_q;
  logic [CNT_WIDTH-1:0]    sat_cnt_q;

  logic                    s2_adv, s1_adv, accept;
  logic [3:0]              sel_factor;
  logic signed [SW-1:0]    u_x, z_x, a_x, term_a, term_b, sum_d;
  logic signed [WIDTH-1:0] clip_d;
  logic                    sat_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        factor_q[i] <= 4'b0100;
        addend_q[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_ch == CH_BITS'(i)) begin
          factor_q[i] <= cfg_factor;
          addend_q[i] <= cfg_addend;
        end
      end
    end
  end

  // Unmatched channel indices fall back to the identity parameters (x1, +0).
  always_comb begin
    sel_factor = 4'b0100;
    a_x        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ch == CH_BITS'(i)) begin
        sel_factor = factor_q[i];
        a_x        = SW'(addend_q[i]);
      end
    end
    u_x = SW'(u);
    z_x = SW'(z);
    unique case (sel_factor[3:2])
      2'b00:   term_a = '0;
      2'b01:   term_a = z_x;
      2'b10:   term_a = z_x >>> 2;
      default: term_a = z_x <<< 2;
    endcase
    unique case (sel_factor[1:0])
      2'b00:   term_b = '0;
      2'b01:   term_b = z_x >>> 1;
      2'b10:   term_b = z_x <<< 1;
      default: term_b = z_x <<< 3;
    endcase
    sum_d = u_x + a_x + term_a + term_b;
  end

  always_comb begin
    clip_d = s1_sum_q[WIDTH-1:0];
    sat_d  = 1'b0;
    if (s1_sum_q > MAX_V) begin
      clip_d = MAX_V[WIDTH-1:0];
      sat_d  = 1'b1;
    end else if (s1_sum_q < MIN_V) begin
      clip_d = MIN_V[WIDTH-1:0];
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      s2_val_q   <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_ch_q  <= in_ch;
          s1_sum_q <= sum_d;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_ch_q  <= s1_ch_q;
          s2_val_q <= clip_d;
          s2_sat_q <= sat_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt_q <= '0;
    else if (sat_clr)
      sat_cnt_q <= '0;
    else if (s2_valid_q && out_ready && s2_sat_q && !(&sat_cnt_q))
      sat_cnt_q <= sat_cnt_q + 1'b1;
  end

  assign out_valid = s2_valid_q;
  assign out_ch    = s2_ch_q;
  assign u_out     = s2_val_q;
  assign out_sat   = s2_sat_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_batch_normalization_pipelined.sv
// Directed bench for batch_normalization_pipelined (WIDTH=6, CHANNELS=4); expected values hand-computed.
module tb_batch_normalization_pipelined;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_we;
  logic [1:0] cfg_ch;
  logic [3:0] cfg_factor;
  logic signed [3:0] cfg_addend;
  logic in_valid, in_ready;
  logic [1:0] in_ch;
  logic signed [5:0] u, z;
  logic out_valid, out_ready;
  logic [1:0] out_ch;
  logic signed [5:0] u_out;
  logic out_sat;
  logic [7:0] sat_count;
  logic sat_clr;

  int n_cmp = 0;
  int n_mis = 0;

  batch_normalization_pipelined dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_factor(cfg_factor), .cfg_addend(cfg_addend),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .u(u), .z(z),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .u_out(u_out),
    .out_sat(out_sat), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic [1:0] ch, input logic [3:0] f, input int a);
    cfg_we = 1'b1; cfg_ch = ch; cfg_factor = f; cfg_addend = 4'(a);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Sends one sample with out_ready=1 and returns the result once it transfers.
  task automatic do_sample(input logic [1:0] ch, input int uv, input int zv,
                           output int res, output logic sat, output logic [1:0] och);
    int n;
    in_ch = ch; u = 6'(uv); z = 6'(zv); in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (!out_valid) begin
      n_mis++;
      $display("FAIL sample_timeout: out_valid=%0b required 1", out_valid);
    end
    res = u_out; sat = out_sat; och = out_ch;
    $display("sample ch=%0d u=%0d z=%0d -> u_out=%0d sat=%0b out_ch=%0d", ch, uv, zv, res, sat, och);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 0; cfg_ch = 0; cfg_factor = 0; cfg_addend = 0;
    in_valid = 0; in_ch = 0; u = 0; z = 0; out_ready = 1; sat_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || u_out !== 6'sd0 || out_ch !== 2'd0 || out_sat !== 1'b0 || sat_count !== 8'd0) begin
      n_mis++;
      $display("FAIL reset_state: valid=%0b u_out=%0d ch=%0d sat=%0b cnt=%0d required 0/0/0/0/0",
               out_valid, u_out, out_ch, out_sat, sat_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    in_ch = 0; u = 6'sd5; z = 6'sd3; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL latency_early: out_valid=%0b required 0 one cycle after accept", out_valid);
    end
    @(posedge clk); #1;
    $display("basic ch=0 u=5 z=3 -> valid=%0b u_out=%0d sat=%0b", out_valid, u_out, out_sat);
    n_cmp++;
    if (out_valid !== 1'b1 || u_out !== 6'sd8 || out_sat !== 1'b0 || out_ch !== 2'd0) begin
      n_mis++;
      $display("FAIL basic_x1: valid=%0b u_out=%0d sat=%0b ch=%0d required 1/8/0/0",
               out_valid, u_out, out_sat, out_ch);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL basic_no_dup: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_factors();
    int r; logic s; logic [1:0] c;
    cfg_write(2'd1, 4'b0011, 0);
    do_sample(2'd1, 0, 3, r, s, c);
    n_cmp++;
    if (r != 24 || s !== 1'b0 || c !== 2'd1) begin
      n_mis++; $display("FAIL x8_z3: u_out=%0d sat=%0b ch=%0d required 24/0/1", r, s, c);
    end
    do_sample(2'd1, 0, 4, r, s, c);
    n_cmp++;
    if (r != 31 || s !== 1'b1) begin
      n_mis++; $display("FAIL x8_z4_sat: u_out=%0d sat=%0b required 31/1", r, s);
    end
    n_cmp++;
    if (sat_count !== 8'd1) begin
      n_mis++; $display("FAIL sat_count_1: got %0d required 1", sat_count);
    end
    cfg_write(2'd2, 4'b1000, -1);
    do_sample(2'd2, 0, -5, r, s, c);
    n_cmp++;
    if (r != -3 || s !== 1'b0 || c !== 2'd2) begin
      n_mis++; $display("FAIL quarter_floor: u_out=%0d sat=%0b ch=%0d required -3/0/2", r, s, c);
    end
    cfg_write(2'd3, 4'b1111, 0);
    do_sample(2'd3, 0, -3, r, s, c);
    n_cmp++;
    if (r != -32 || s !== 1'b1 || c !== 2'd3) begin
      n_mis++; $display("FAIL x12_neg_sat: u_out=%0d sat=%0b ch=%0d required -32/1/3", r, s, c);
    end
    n_cmp++;
    if (sat_count !== 8'd2) begin
      n_mis++; $display("FAIL sat_count_2: got %0d required 2", sat_count);
    end
  endtask

  task automatic test_back_to_back();
    int uin [4] = '{10, -7, 3, 20};
    int exp_v [4] = '{11, -6, 4, 21};
    int acc = 0;
    int got = 0;
    logic xin, xout;
    logic signed [5:0] held = '0;
    in_ch = 0; z = 6'sd1; u = 6'(uin[0]); in_valid = 1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      out_ready = (c >= 3);
      #1;
      if (c == 2) begin
        n_cmp++;
        if (in_ready !== 1'b0 || acc != 2) begin
          n_mis++; $display("FAIL backpressure: in_ready=%0b accepted=%0d required 0/2", in_ready, acc);
        end
        held = u_out;
      end
      if (c == 3) begin
        n_cmp++;
        if (out_valid !== 1'b1 || u_out !== held) begin
          n_mis++; $display("FAIL stall_hold: valid=%0b u_out=%0d required 1/%0d", out_valid, u_out, held);
        end
      end
      xin  = in_valid && in_ready;
      xout = out_valid && out_ready;
      if (xout) begin
        $display("stream out #%0d u_out=%0d ch=%0d", got, u_out, out_ch);
        n_cmp++;
        if (u_out != exp_v[got] || out_ch !== 2'd0) begin
          n_mis++; $display("FAIL stream_order_%0d: u_out=%0d ch=%0d required %0d/0", got, u_out, out_ch, exp_v[got]);
        end
        got++;
      end
      @(posedge clk); #1;
      if (xin) begin
        acc++;
        if (acc < 4) u = 6'(uin[acc]);
        else in_valid = 0;
      end
    end
    n_cmp++;
    if (got != 4 || out_valid !== 1'b0) begin
      n_mis++; $display("FAIL stream_count: outputs=%0d trailing_valid=%0b required 4/0", got, out_valid);
    end
  endtask

  task automatic test_same_cycle_cfg();
    int r; logic s; logic [1:0] c;
    cfg_we = 1; cfg_ch = 0; cfg_factor = 4'b0010; cfg_addend = 0;
    in_ch = 0; u = 6'sd0; z = 6'sd2; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    cfg_we = 0; in_valid = 0;
    @(posedge clk); #1;
    $display("same-cycle cfg sample -> valid=%0b u_out=%0d", out_valid, u_out);
    n_cmp++;
    if (out_valid !== 1'b1 || u_out !== 6'sd2) begin
      n_mis++; $display("FAIL cfg_old_params: valid=%0b u_out=%0d required 1/2", out_valid, u_out);
    end
    @(posedge clk); #1;
    do_sample(2'd0, 0, 2, r, s, c);
    n_cmp++;
    if (r != 4) begin
      n_mis++; $display("FAIL cfg_new_params: u_out=%0d required 4", r);
    end
  endtask

  task automatic test_reset_mid();
    int r; logic s; logic [1:0] c;
    out_ready = 0; in_ch = 2; u = 6'sd1; z = 6'sd0; in_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_mis++; $display("FAIL prefill: valid=%0b in_ready=%0b required 1/0", out_valid, in_ready);
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || u_out !== 6'sd0 || sat_count !== 8'd0 || in_ready !== 1'b1) begin
      n_mis++; $display("FAIL async_reset: valid=%0b u_out=%0d cnt=%0d in_ready=%0b required 0/0/0/1",
                        out_valid, u_out, sat_count, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_mis++; $display("FAIL reset_flushed: out_valid=%0b required 0", out_valid);
    end
    do_sample(2'd0, 0, 2, r, s, c);
    n_cmp++;
    if (r != 2) begin
      n_mis++; $display("FAIL reset_factor: u_out=%0d required 2", r);
    end
    do_sample(2'd2, 0, -5, r, s, c);
    n_cmp++;
    if (r != -5) begin
      n_mis++; $display("FAIL reset_addend: u_out=%0d required -5", r);
    end
  endtask

  task automatic test_sat_count();
    cfg_write(2'd3, 4'b1111, 7);
    in_ch = 3; u = 6'sd31; z = 6'sd31; in_valid = 1; out_ready = 1;
    repeat (262) @(posedge clk);
    #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("sat stream done: sat_count=%0d", sat_count);
    n_cmp++;
    if (sat_count !== 8'd255) begin
      n_mis++; $display("FAIL sat_count_hold: got %0d required 255", sat_count);
    end
    in_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    sat_clr = 1;
    n_cmp++;
    if (!(out_valid && out_ready && out_sat)) begin
      n_mis++; $display("FAIL clr_setup: valid=%0b sat=%0b required 1/1", out_valid, out_sat);
    end
    @(posedge clk); #1;
    sat_clr = 0;
    n_cmp++;
    if (sat_count !== 8'd0) begin
      n_mis++; $display("FAIL sat_clr_priority: got %0d required 0", sat_count);
    end
    @(posedge clk); #1;
    in_valid = 0;
    n_cmp++;
    if (sat_count !== 8'd1) begin
      n_mis++; $display("FAIL sat_after_clr: got %0d required 1", sat_count);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_factors();
    test_back_to_back();
    test_same_cycle_cfg();
    test_reset_mid();
    test_sat_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
